sig_rom_arbiter: RTL and testbench

//  Shares one Sig_ROM sigmoid lookup among numReq neurons of a layer.

---
 rtl/sig_rom_arbiter.sv | 127 ++++++++++++
 tb/tb_sig_rom_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sig_rom_arbiter.sv
// Shares one Sig_ROM among numReq neurons: round-robin grant, registered ROM address,
// and a two-stage id tag pipeline that realigns each ROM word with its requester.
// Define SIG_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module sig_rom_arbiter #(
    parameter int unsigned numReq    = 4,
    parameter int unsigned inWidth   = 10,
    parameter int unsigned dataWidth = 16,
    localparam int unsigned idWidth  = (numReq > 1) ? $clog2(numReq) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [numReq-1:0]             req,
    input  logic [numReq*inWidth-1:0]     x,
    output logic [numReq-1:0]             gnt,
    output logic [inWidth-1:0]            rom_x,
    input  logic [dataWidth-1:0]          rom_out,
    output logic                          rsp_valid,
    output logic [idWidth-1:0]            rsp_id,
    output logic [dataWidth-1:0]          rsp_data,
    output logic                          busy
);

    typedef struct packed {
        logic               valid;
        logic [idWidth-1:0] id;
    } tag_t;

    logic [idWidth-1:0]   ptr_q,      ptr_d;
    logic [inWidth-1:0]   rom_x_q,    rom_x_d;
    tag_t                 tag0_q,     tag0_d;
    tag_t                 tag1_q,     tag1_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [idWidth-1:0]   rsp_id_q,   rsp_id_d;
    logic [dataWidth-1:0] rsp_data_q, rsp_data_d;
    logic                 busy_q,     busy_d;

    logic                 win_v_c;
    logic [idWidth-1:0]   win_id_c;
    logic [inWidth-1:0]   x_arr [numReq];

    for (genvar g = 0; g < numReq; g++) begin : g_slice
        assign x_arr[g] = x[g*inWidth +: inWidth];
    end

    // Scan requests starting at ptr, wrapping; reset masks any grant.
    always_comb begin
        int unsigned idx;
        idx      = 0;
        win_v_c  = 1'b0;
        win_id_c = '0;
        for (int unsigned k = 0; k < numReq; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= numReq) begin
                idx = idx - numReq;
            end
            if (!win_v_c && req[idWidth'(idx)]) begin
                win_v_c  = 1'b1;
                win_id_c = idWidth'(idx);
            end
        end
        if (rst) begin
            win_v_c = 1'b0;
        end
    end

    always_comb begin
        gnt = '0;
        if (win_v_c) begin
            gnt[win_id_c] = 1'b1;
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        rom_x_d     = rom_x_q;
        tag0_d      = '0;
        tag1_d      = tag0_q;
        rsp_valid_d = tag1_q.valid;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        if (win_v_c) begin
            rom_x_d     = x_arr[win_id_c];
            tag0_d.valid = 1'b1;
            tag0_d.id    = win_id_c;
`ifdef SIG_ARB_FIXED_PRIO_EN
            ptr_d = '0;
`else
            ptr_d = (32'(win_id_c) == numReq - 1) ? '0 : idWidth'(win_id_c + 1'b1);
`endif
        end
        // ROM word for tag1 is on rom_out now (ROM registered the address one edge ago).
        if (tag1_q.valid) begin
            rsp_id_d   = tag1_q.id;
            rsp_data_d = rom_out;
        end
        busy_d = tag0_d.valid | tag1_d.valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            rom_x_q     <= '0;
            tag0_q      <= '0;
            tag1_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            rom_x_q     <= rom_x_d;
            tag0_q      <= tag0_d;
            tag1_q      <= tag1_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
        end
    end

    assign rom_x     = rom_x_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sig_rom_arbiter.sv
// Bench for sig_rom_arbiter: directed scenarios then random traffic, checked against a
// grant-order / response-queue model and a behavioural Sig_ROM with mem[k]=k.
module tb_sig_rom_arbiter;
    localparam int N  = 4;
    localparam int IW = 10;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*IW-1:0] x;
    logic [N-1:0]    gnt;
    logic [IW-1:0]   rom_x;
    logic [DW-1:0]   rom_out;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic [DW-1:0]   rsp_data;
    logic            busy;

    always #5 clk = ~clk;

    sig_rom_arbiter #(.numReq(N), .inWidth(IW), .dataWidth(DW)) dut (
        .clk(clk), .rst(rst), .req(req), .x(x), .gnt(gnt), .rom_x(rom_x),
        .rom_out(rom_out), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .busy(busy)
    );

    // Sig_ROM: signed address offset by half the table, registered output
    logic [DW-1:0] mem [1024];
    logic [IW-1:0] rom_addr;
    assign rom_addr = rom_x + 10'd512;
    always @(posedge clk) rom_out <= mem[rom_addr];

    typedef struct { int due; int id; int data; } rsp_t;
    rsp_t exp_q[$];
    int   gnt_log[$];
    int   rspid_log[$];
    int   rspdat_log[$];
    int   cyc = 0, ptr_m = 0, rom_x_m = 0, last_id = 0, last_data = 0, last_win = -1;
    int   n_checks = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int x_of(input int i);
        logic [IW-1:0] v;
        v = x[i*IW +: IW];
        return int'(v);
    endfunction

    function automatic int model_winner();
        if (rst) return -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr_m + k) % N;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    task automatic set_x(input int i, input int v);
        x[i*IW +: IW] = IW'(v);
    endtask

    task automatic clear_logs();
        gnt_log.delete(); rspid_log.delete(); rspdat_log.delete();
    endtask

    // One clock: check current outputs against the model, then advance the model at posedge.
    task automatic cycle();
        int w, busy_exp;
        logic [N-1:0] g_exp;
        #1;
        w = model_winner();
        g_exp = '0;
        if (w >= 0) g_exp[w] = 1'b1;
        check("gnt", 32'(gnt), 32'(g_exp));
        check("rom_x", 32'(rom_x), rom_x_m);
        busy_exp = 0;
        foreach (exp_q[j]) if (exp_q[j].due > cyc) busy_exp = 1;
        check("busy", 32'(busy), busy_exp);
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            check("rsp_valid", 32'(rsp_valid), 1);
            last_id   = exp_q[0].id;
            last_data = exp_q[0].data;
            void'(exp_q.pop_front());
        end else begin
            check("rsp_valid", 32'(rsp_valid), 0);
        end
        check("rsp_id", 32'(rsp_id), last_id);
        check("rsp_data", 32'(rsp_data), last_data);
        for (int i = 0; i < N; i++) if (gnt[i] === 1'b1) gnt_log.push_back(i);
        if (rsp_valid === 1'b1) begin
            rspid_log.push_back(int'(rsp_id));
            rspdat_log.push_back(int'(rsp_data));
        end
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            ptr_m = 0; rom_x_m = 0; last_id = 0; last_data = 0; w = -1;
        end else if (w >= 0) begin
            exp_q.push_back('{due: cyc + 3, id: w, data: (x_of(w) + 512) % 1024});
            rom_x_m = x_of(w);
`ifdef SIG_ARB_FIXED_PRIO_EN
            ptr_m = 0;
`else
            ptr_m = (w + 1) % N;
`endif
        end
        last_win = w;
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req = '0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int exp_order [8];
        int exp_1001 [4];
        for (int k = 0; k < 1024; k++) mem[k] = DW'(k);
        rst = 1'b1; req = '0; x = '0;
        @(posedge clk);
        @(negedge clk);

        // reset held with all requests up: grants must stay low
        req = 4'b1111;
        cycle();
        rst = 1'b0;

        // single lookup from neuron 2 at x=0
        clear_logs();
        req = 4'b0100; set_x(2, 0);
        cycle();
        idle(4);
        check("t1_rsp_count", rspid_log.size(), 1);
        if (rspid_log.size() == 1) begin
            check("t1_rsp_id", rspid_log[0], 2);
            check("t1_rsp_data", rspdat_log[0], 512);
        end

        // all four requesting continuously from reset
        do_reset();
        clear_logs();
        for (int i = 0; i < N; i++) set_x(i, i);
        req = 4'b1111;
        for (int i = 0; i < 8; i++) cycle();
        idle(3);
`ifdef SIG_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
        check("t2_gnt_count", gnt_log.size(), 8);
        check("t2_rsp_count", rspid_log.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < gnt_log.size()) check("t2_gnt_order", gnt_log[i], exp_order[i]);
            if (i < rspid_log.size()) begin
                check("t2_rsp_id", rspid_log[i], exp_order[i]);
                check("t2_rsp_data", rspdat_log[i], 512 + exp_order[i]);
            end
        end

        // neurons 0 and 3 only
        do_reset();
        clear_logs();
        req = 4'b1001;
        for (int i = 0; i < 4; i++) cycle();
        idle(3);
`ifdef SIG_ARB_FIXED_PRIO_EN
        exp_1001 = '{0, 0, 0, 0};
`else
        exp_1001 = '{0, 3, 0, 3};
`endif
        check("t3_gnt_count", gnt_log.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < gnt_log.size()) check("t3_gnt_order", gnt_log[i], exp_1001[i]);

        // negative operand -1
        clear_logs();
        req = 4'b0010; set_x(1, 10'h3FF);
        cycle();
        idle(3);
        check("t4_rsp_count", rspid_log.size(), 1);
        if (rspid_log.size() == 1) begin
            check("t4_rsp_id", rspid_log[0], 1);
            check("t4_rsp_data", rspdat_log[0], 511);
        end

        // two lookups in flight, then reset drops them
        set_x(0, 5); set_x(1, 7);
        req = 4'b0011;
        cycle();
        req = (last_win == 0) ? 4'b0010 : 4'b0001;
        cycle();
        clear_logs();
        do_reset();
        check("t5_busy_after_rst", 32'(busy), 0);
        req = 4'b0010; set_x(1, 20);
        cycle();
        idle(5);
        check("t5_rsp_count", rspid_log.size(), 1);
        if (rspid_log.size() == 1) begin
            check("t5_rsp_id", rspid_log[0], 1);
            check("t5_rsp_data", rspdat_log[0], 532);
        end

        // random traffic obeying the hold-until-granted rule
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            for (int i = 0; i < N; i++) begin
                if (req[i] == 1'b0 || last_win == i) begin
                    req[i] = 1'($urandom_range(0, 1));
                    set_x(i, int'($urandom_range(0, 1023)));
                end
            end
            cycle();
        end
        rst = 1'b0;
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
